// File: rtl/pipe_ctrl_unit.sv
// Registered ID-stage decode/control unit: decodes instr into the ID/EX bundle,
// and handles load-use stalls, branch/jump flushes, call-depth tracking and halt.
module pipe_ctrl_unit #(
   parameter  int INSTR_W      = 19,
   parameter  int REG_W        = 3,
   parameter  int STACK_DEPTH  = 8,
   parameter  int FLUSH_CYCLES = 1,
   localparam int DEPTH_W      = $clog2(STACK_DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               instr_valid,
   input  logic [INSTR_W-1:0] instr,
   input  logic [REG_W-1:0]   rs1,
   input  logic [REG_W-1:0]   rs2,
   input  logic [REG_W-1:0]   rd,
   input  logic               zero,
   input  logic               carry,
   output logic               reg2_read_source,
   output logic               mem_read_write,
   output logic               mem_or_alu,
   output logic               is_shift,
   output logic               alu_src,
   output logic               update_z_c,
   output logic               reg_write_signal,
   output logic               stack_push,
   output logic               stack_pop,
   output logic [1:0]         pc_src,
   output logic [1:0]         scode,
   output logic [2:0]         acode,
   output logic               stall,
   output logic               flush,
   output logic               halted,
   output logic               stack_err,
   output logic [DEPTH_W-1:0] depth,
   output logic [1:0]         dbg_state
);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_FLUSH   = 2'd1,
      ST_HALTED  = 2'd2
   } state_e;

   typedef struct packed {
      logic       reg2_read_source;
      logic       mem_read_write;
      logic       mem_or_alu;
      logic       is_shift;
      logic       alu_src;
      logic       update_z_c;
      logic       reg_write_signal;
      logic       stack_push;
      logic       stack_pop;
      logic [1:0] pc_src;
      logic [1:0] scode;
      logic [2:0] acode;
   } ctrl_t;

   localparam logic [DEPTH_W-1:0] MAX_DEPTH  = DEPTH_W'(STACK_DEPTH);
   localparam logic [1:0]         FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

   state_e               state_q, state_d;
   logic [1:0]           cnt_q, cnt_d;
   logic [DEPTH_W-1:0]   depth_q, depth_d;
   logic                 ld_valid_q, ld_valid_d;
   logic [REG_W-1:0]     ld_rd_q, ld_rd_d;
   ctrl_t                ctrl_q, ctrl_d;
   logic                 flush_q, flush_d;
   logic                 halted_q, halted_d;
   logic                 err_q, err_d;
   logic                 stall_c;

   // Opcode classification from the top six instruction bits.
   logic [5:0] op;
   logic [1:0] sub;
   logic       is_rtype, is_imm, is_shift_op, is_load, is_store, is_branch;
   logic       is_jmp_grp, is_jsb, is_ret, is_halt, br_taken, hazard;
   logic       unused_low_bits;

   assign op          = instr[INSTR_W-1 -: 6];
   assign sub         = op[2:1];
   assign is_rtype    = (op[5:4] == 2'b00);
   assign is_imm      = (op[5:4] == 2'b01);
   assign is_shift_op = (op[5:3] == 3'b110);
   assign is_load     = (op[5:3] == 3'b100) && (sub == 2'b00);
   assign is_store    = (op[5:3] == 3'b100) && (sub == 2'b01);
   assign is_branch   = (op[5:3] == 3'b101);
   assign is_jmp_grp  = (op[5:2] == 4'b1110);
   assign is_jsb      = is_jmp_grp && op[1];
   assign is_ret      = (op == 6'b111100);
   assign is_halt     = (op == 6'b111111);
   assign unused_low_bits = ^instr[INSTR_W-7:0];

   always_comb begin
      br_taken = 1'b0;
      case (sub)
         2'b00:   br_taken = zero;
         2'b01:   br_taken = !zero;
         2'b10:   br_taken = carry;
         default: br_taken = !carry;
      endcase
   end

   // rs2 is only a real read operand for R-type, branch and store.
   assign hazard = ld_valid_q &&
                   ((rs1 == ld_rd_q) ||
                    ((rs2 == ld_rd_q) && (is_rtype || is_branch || is_store)));

   // instr_valid qualifies instr; while stall is high the instruction is not
   // consumed and the fetch side must present it again next cycle.
   always_comb begin
      logic go_flush;
      state_d    = state_q;
      cnt_d      = cnt_q;
      depth_d    = depth_q;
      ld_valid_d = ld_valid_q;
      ld_rd_d    = ld_rd_q;
      ctrl_d     = '0;
      flush_d    = 1'b0;
      halted_d   = 1'b0;
      err_d      = 1'b0;
      stall_c    = 1'b0;
      go_flush   = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (instr_valid) begin
               if (hazard) begin
                  stall_c    = 1'b1;
                  ld_valid_d = 1'b0;
               end else begin
                  ld_valid_d = is_load;
                  if (is_load) ld_rd_d = rd;

                  if (is_rtype || is_imm) begin
                     ctrl_d.update_z_c       = 1'b1;
                     ctrl_d.mem_or_alu       = 1'b1;
                     ctrl_d.reg_write_signal = 1'b1;
                     ctrl_d.alu_src          = is_imm;
                     ctrl_d.acode            = op[3:1];
                  end else if (is_shift_op) begin
                     ctrl_d.is_shift         = 1'b1;
                     ctrl_d.mem_or_alu       = 1'b1;
                     ctrl_d.reg_write_signal = 1'b1;
                     ctrl_d.update_z_c       = 1'b1;
                     ctrl_d.scode            = sub;
                  end else if (is_load) begin
                     ctrl_d.reg2_read_source = 1'b1;
                     ctrl_d.alu_src          = 1'b1;
                     ctrl_d.reg_write_signal = 1'b1;
                  end else if (is_store) begin
                     ctrl_d.reg2_read_source = 1'b1;
                     ctrl_d.alu_src          = 1'b1;
                     ctrl_d.mem_read_write   = 1'b1;
                  end else if (is_branch) begin
                     if (br_taken) begin
                        ctrl_d.pc_src = 2'b11;
                        go_flush      = 1'b1;
                     end
                  end else if (is_jmp_grp) begin
                     ctrl_d.pc_src = 2'b01;
                     go_flush      = 1'b1;
                     // A jsb with a full stack degrades to a plain jmp.
                     if (is_jsb) begin
                        if (depth_q == MAX_DEPTH) begin
                           err_d = 1'b1;
                        end else begin
                           ctrl_d.stack_push = 1'b1;
                           depth_d           = depth_q + DEPTH_W'(1);
                        end
                     end
                  end else if (is_ret) begin
                     if (depth_q == '0) begin
                        err_d = 1'b1;
                     end else begin
                        ctrl_d.pc_src    = 2'b10;
                        ctrl_d.stack_pop = 1'b1;
                        depth_d          = depth_q - DEPTH_W'(1);
                        go_flush         = 1'b1;
                     end
                  end else if (is_halt) begin
                     state_d  = ST_HALTED;
                     halted_d = 1'b1;
                  end
               end
            end
            if (go_flush) begin
               state_d = ST_FLUSH;
               cnt_d   = FLUSH_INIT;
               flush_d = 1'b1;
            end
         end
         ST_FLUSH: begin
            if (cnt_q == 2'd0) begin
               state_d = ST_RUN;
            end else begin
               cnt_d   = cnt_q - 2'd1;
               flush_d = 1'b1;
            end
         end
         ST_HALTED: begin
            halted_d = 1'b1;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_RUN;
         cnt_q      <= 2'd0;
         depth_q    <= '0;
         ld_valid_q <= 1'b0;
         ld_rd_q    <= '0;
         ctrl_q     <= '0;
         flush_q    <= 1'b0;
         halted_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         depth_q    <= depth_d;
         ld_valid_q <= ld_valid_d;
         ld_rd_q    <= ld_rd_d;
         ctrl_q     <= ctrl_d;
         flush_q    <= flush_d;
         halted_q   <= halted_d;
         err_q      <= err_d;
      end
   end

   assign reg2_read_source = ctrl_q.reg2_read_source;
   assign mem_read_write   = ctrl_q.mem_read_write;
   assign mem_or_alu       = ctrl_q.mem_or_alu;
   assign is_shift         = ctrl_q.is_shift;
   assign alu_src          = ctrl_q.alu_src;
   assign update_z_c       = ctrl_q.update_z_c;
   assign reg_write_signal = ctrl_q.reg_write_signal;
   assign stack_push       = ctrl_q.stack_push;
   assign stack_pop        = ctrl_q.stack_pop;
   assign pc_src           = ctrl_q.pc_src;
   assign scode            = ctrl_q.scode;
   assign acode            = ctrl_q.acode;
   assign stall            = stall_c;
   assign flush            = flush_q;
   assign halted           = halted_q;
   assign stack_err        = err_q;
   assign depth            = depth_q;
   assign dbg_state        = state_q;

endmodule
